arith_arbiter: RTL and testbench

ARITH_ARBITER -- requirements
Module: arith_arbiter

---
 rtl/arith_arbiter.sv | 142 ++++++++++++++
 tb/tb_arith_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/arith_arbiter.sv
// Two-requester round-robin front end for a single shared arithmetic unit.
// One operation in flight at a time: grant in IDLE, one-cycle enable in ISSUE,
// wait for the unit's result flag in WAIT, hold the response in RESP until taken.
// Divide-by-zero is resolved locally and never reaches the unit.
module arith_arbiter #(
  parameter int In_Data_Width = 8,
  parameter int Out_Width     = 2*In_Data_Width
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  input  logic                     req1_valid,
  output logic                     req0_ready,
  output logic                     req1_ready,
  input  logic [In_Data_Width-1:0] req0_a,
  input  logic [In_Data_Width-1:0] req0_b,
  input  logic [In_Data_Width-1:0] req1_a,
  input  logic [In_Data_Width-1:0] req1_b,
  input  logic [1:0]               req0_fun,
  input  logic [1:0]               req1_fun,
  output logic [In_Data_Width-1:0] alu_a,
  output logic [In_Data_Width-1:0] alu_b,
  output logic [1:0]               alu_fun,
  output logic                     alu_enable,
  input  logic [Out_Width-1:0]     alu_out,
  input  logic                     alu_flag,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [Out_Width-1:0]     rsp_data,
  output logic                     rsp_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] FUN_DIV = 2'b11;

  logic [1:0]               state_q, state_d;
  logic                     prio_q, prio_d;   // requester favoured on a tie
  logic                     id_q, id_d;       // requester owning the current op
  logic [In_Data_Width-1:0] a_q, a_d;
  logic [In_Data_Width-1:0] b_q, b_d;
  logic [1:0]               fun_q, fun_d;
  logic [Out_Width-1:0]     rsp_data_q, rsp_data_d;
  logic                     rsp_err_q, rsp_err_d;

  logic any_req;
  logic gnt;
  logic alu_live;

  // Next-state logic: arbitration and operand capture in IDLE, sequencing after.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    fun_d      = fun_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    any_req    = req0_valid | req1_valid;
    // Lone requester wins outright; a tie goes to the favoured one.
    gnt        = (req0_valid & req1_valid) ? prio_q : req1_valid;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          // Gating with rst keeps the accept pulse low while reset is held.
          req0_ready = rst & ~gnt;
          req1_ready = rst & gnt;
          id_d       = gnt;
          a_d        = gnt ? req1_a   : req0_a;
          b_d        = gnt ? req1_b   : req0_b;
          fun_d      = gnt ? req1_fun : req0_fun;
          if (fun_d == FUN_DIV && b_d == '0) begin
            state_d    = S_RESP;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (alu_flag) begin
          rsp_data_d = alu_out;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          prio_d  = ~id_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset returns to IDLE with requester 0 favoured.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      prio_q     <= 1'b0;
      id_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      fun_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      id_q       <= id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      fun_q      <= fun_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Unit sees operands only while it owns the op; zero otherwise.
  assign alu_live   = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign alu_enable = (state_q == S_ISSUE);
  assign alu_a      = alu_live ? a_q   : '0;
  assign alu_b      = alu_live ? b_q   : '0;
  assign alu_fun    = alu_live ? fun_q : '0;

  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_id     = id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_arith_arbiter.sv
// Directed + randomized bench for arith_arbiter with a behavioural unit model
// and a result/round-robin reference computed from request operands.
module tb_arith_arbiter;

  localparam int IW = 8;
  localparam int OW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [IW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]    req0_fun, req1_fun;
  logic [IW-1:0] alu_a, alu_b;
  logic [1:0]    alu_fun;
  logic          alu_enable;
  logic [OW-1:0] alu_out;
  logic          alu_flag;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [OW-1:0] rsp_data;

  int n_chk  = 0;
  int n_pass = 0;
  int prio   = 0;   // reference round-robin: requester favoured on a tie
  int alu_lat = 1;  // cycles from enable-cycle to result flag
  int alu_cnt = 0;
  int alu_res = 0;

  arith_arbiter #(.In_Data_Width(IW), .Out_Width(OW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_fun(req0_fun), .req1_fun(req1_fun),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_enable(alu_enable),
    .alu_out(alu_out), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  function automatic int ref_res(input logic [1:0] f, input logic [IW-1:0] a, input logic [IW-1:0] b);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (f)
      2'd0:    return sa + sb;
      2'd1:    return sa - sb;
      2'd2:    return sa * sb;
      default: return (sb == 0) ? 0 : sa / sb;
    endcase
  endfunction

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Shared unit model: sees the enable cycle, raises the flag alu_lat cycles later.
  initial begin
    alu_flag = 1'b0;
    alu_out  = '0;
    forever begin
      @(negedge clk);
      alu_flag = 1'b0;
      if (alu_cnt > 0) begin
        alu_cnt--;
        if (alu_cnt == 0) begin
          alu_flag = 1'b1;
          alu_out  = OW'(alu_res);
        end
      end
      if (alu_enable) begin
        alu_cnt = alu_lat;
        alu_res = ref_res(alu_fun, alu_a, alu_b);
      end
    end
  end

  // One full transaction: present requests, check grant, latency, result, backpressure.
  task automatic run(input bit v0, input bit v1,
                     input logic [IW-1:0] a0, input logic [IW-1:0] b0, input logic [1:0] f0,
                     input logic [IW-1:0] a1, input logic [IW-1:0] b1, input logic [1:0] f1,
                     input int lat, input int bp);
    int gnt, exp, lat_exp, cyc, en_cnt, rdy_cnt, hold_bad, stable_bad;
    bit dz;
    logic [IW-1:0] ea, eb;
    logic [1:0] ef;
    logic [OW-1:0] d0;
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req0_fun = f0;
    req1_a = a1; req1_b = b1; req1_fun = f1;
    alu_lat = lat;
    gnt = (v0 && v1) ? prio : (v1 ? 1 : 0);
    ea = (gnt == 1) ? a1 : a0;
    eb = (gnt == 1) ? b1 : b0;
    ef = (gnt == 1) ? f1 : f0;
    dz = (ef == 2'd3) && (eb == '0);
    exp = dz ? 0 : ref_res(ef, ea, eb);
    lat_exp = dz ? 1 : 2 + lat;
    #1;
    chk("grant0", req0_ready, (gnt == 0));
    chk("grant1", req1_ready, (gnt == 1));
    cyc = 0; en_cnt = 0; rdy_cnt = 0; hold_bad = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk); #1;
      cyc = i;
      if (req0_ready || req1_ready) rdy_cnt++;
      if (rsp_valid) break;
      if (alu_enable) en_cnt++;
      if (!dz && (alu_a !== ea || alu_b !== eb || alu_fun !== ef)) hold_bad++;
    end
    chk("latency", cyc, lat_exp);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, gnt);
    chk("rsp_data", $signed(rsp_data), exp);
    chk("rsp_err", rsp_err, dz);
    chk("enable_pulses", en_cnt, dz ? 0 : 1);
    chk("alu_hold", hold_bad, 0);
    chk("ready_outside_idle", rdy_cnt, 0);
    d0 = rsp_data;
    stable_bad = 0;
    repeat (bp) begin
      @(negedge clk); #1;
      if (!rsp_valid || rsp_data !== d0 || rsp_id !== gnt[0] || req0_ready || req1_ready)
        stable_bad++;
    end
    if (bp > 0) chk("rsp_stable_bp", stable_bad, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_released", rsp_valid, 0);
    prio = (gnt == 1) ? 0 : 1;
  endtask

  initial begin
    int stray_rsp, flag_seen, v;
    logic [IW-1:0] ra0, rb0, ra1, rb1;
    rst = 1'b0;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    req0_fun = '0; req1_fun = '0;
    @(negedge clk); #1;
    chk("reset_outputs", {req0_ready, req1_ready, alu_a, alu_b, alu_fun, alu_enable,
                          rsp_valid, rsp_id, rsp_data, rsp_err}, 0);
    @(negedge clk);
    rst = 1'b1;

    // add 100 + -28; grant on the first edge after release
    run(1, 0, 8'd100, 8'(-28), 2'd0, 8'd0, 8'd0, 2'd0, 1, 0);
    // both continuously valid: grants alternate
    repeat (4)
      run(1, 1, 8'(-5), 8'd7, 2'd2, 8'd3, 8'd10, 2'd1, 1, 0);
    // divide by zero resolved locally
    run(0, 1, 8'd0, 8'd0, 2'd0, 8'(-128), 8'd0, 2'd3, 1, 0);
    // mul 127*127 under backpressure
    run(1, 0, 8'd127, 8'd127, 2'd2, 8'd0, 8'd0, 2'd0, 1, 5);
    // extremes: -128 / -1 and -128 * -128
    run(0, 1, 8'd0, 8'd0, 2'd0, 8'(-128), 8'(-1), 2'd3, 2, 0);
    run(1, 1, 8'(-128), 8'(-128), 2'd2, 8'd1, 8'd1, 2'd0, 3, 1);

    // randomized traffic
    for (int k = 0; k < 12; k++) begin
      v = int'($urandom_range(1, 3));
      ra0 = IW'($urandom); rb0 = ($urandom_range(0, 3) == 0) ? '0 : IW'($urandom);
      ra1 = IW'($urandom); rb1 = ($urandom_range(0, 3) == 0) ? '0 : IW'($urandom);
      run(v[0], v[1], ra0, rb0, 2'($urandom_range(0, 3)), ra1, rb1, 2'($urandom_range(0, 3)),
          int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
    end

    // serve requester 0 last so that without reset requester 1 would be favoured
    run(1, 0, 8'd1, 8'd2, 2'd0, 8'd0, 8'd0, 2'd0, 1, 0);

    // reset during WAIT with a slow unit
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = 8'd5; req0_b = 8'd9; req0_fun = 2'd0;
    alu_lat = 8;
    #1;
    chk("pre_reset_grant", req0_ready, 1);
    @(negedge clk); @(negedge clk); #1;
    chk("in_wait_alu_a", alu_a, 5);
    rst = 1'b0;
    #1;
    chk("mid_reset_outputs", {req0_ready, req1_ready, alu_a, alu_b, alu_fun, alu_enable,
                              rsp_valid, rsp_id, rsp_data, rsp_err}, 0);
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b0;
    stray_rsp = 0; flag_seen = 0;
    repeat (12) begin
      @(negedge clk); #1;
      if (rsp_valid || alu_enable) stray_rsp++;
      if (alu_flag) flag_seen++;
    end
    chk("stray_flag_delivered", flag_seen, 1);
    chk("no_stray_rsp", stray_rsp, 0);
    prio = 0;
    run(1, 1, 8'd20, 8'd3, 2'd1, 8'd7, 8'd7, 2'd0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
